divider: RTL
============

DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter LEN, default 32, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  abort current operation; return to IDLE next cycle.
REQ-005 in_valid  input  1  operands presented.
REQ-006 in_ready  output  1  divider can accept operands.
REQ-007 sign  input  sign_t  SIGNED or UNSIGNED interpretation, sampled at accept.
REQ-008 dividend  input  LEN  numerator.
REQ-009 divisor  input  LEN  denominator.
REQ-010 out_valid  output  1  quotient/remainder valid.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 quotient  output  LEN  result quotient.
REQ-013 remainder  output  LEN  result remainder.

Function
REQ-014 FSM states SHALL be IDLE, BUSY, DONE.
REQ-015 in_ready SHALL be 1 in IDLE only; accept = in_valid & in_ready at a rising edge.
REQ-016 On accept, sign, dividend and divisor SHALL be latched; later input changes have no effect.
REQ-017 Normal accept SHALL go IDLE->BUSY; BUSY SHALL last exactly LEN cycles of one restoring step per cycle, MSB first.
REQ-018 Signed mode SHALL divide magnitudes and fix signs at completion: quotient negative iff operand signs differ; remainder takes dividend's sign.
REQ-019 Quotient SHALL truncate toward zero; dividend = quotient*divisor + remainder SHALL hold for all non-special cases.
REQ-020 Divisor==0 (either mode) SHALL skip BUSY, go IDLE->DONE: quotient all ones, remainder = dividend.
REQ-021 Signed dividend==2^(LEN-1) with divisor all ones SHALL skip BUSY, go IDLE->DONE: quotient = dividend, remainder = 0.
REQ-022 BUSY->DONE after LEN-th step; out_valid SHALL be 1 exactly in DONE.
REQ-023 Latency: accept at edge T -> out_valid high from cycle T+LEN+1 (normal) or T+1 (special cases).
REQ-024 quotient/remainder SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 DONE->IDLE on out_valid & out_ready; no new accept in that same cycle (in_ready=0 in DONE).
REQ-026 flush SHALL override all other transitions in any state: next state IDLE, out_valid=0, result discarded.
REQ-027 flush with in_valid in IDLE SHALL NOT accept.
REQ-028 Internal remainder accumulator SHALL be LEN+1 bits to hold the subtraction borrow.

Reset
REQ-029 rst SHALL dominate flush and all inputs; state IDLE next cycle.
REQ-030 After reset: in_ready=1, out_valid=0, quotient=0, remainder=0, step counter=0.
REQ-031 Reset mid-BUSY or in DONE SHALL discard the operation without producing out_valid.

Structure
REQ-032 sign_t (SIGNED/UNSIGNED) SHALL come from the shared core package; divider state enum (div_state_t) SHALL be added to that package.
REQ-033 One combinational sub-module div_step SHALL implement a single restoring iteration (shift, trial subtract, quotient bit); divider instantiates it once.
REQ-034 Step counter SHALL be $clog2(LEN)+1 bits wide.

Verification
REQ-035 UNSIGNED 100/7, out_ready=1 -> out_valid at T+33, quotient=14, remainder=2, back to IDLE at T+34.
REQ-036 SIGNED -7/2 (0xFFFFFFF9/0x00000002) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; SIGNED 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
REQ-037 5/0 both modes -> out_valid at T+1, quotient=0xFFFFFFFF, remainder=5; SIGNED 0x80000000/0xFFFFFFFF -> out_valid at T+1, quotient=0x80000000, remainder=0.
REQ-038 UNSIGNED 0xFFFFFFFF/1 with out_ready=0 for 10 cycles after out_valid -> outputs stable at quotient=0xFFFFFFFF, remainder=0; in_ready=0 throughout; IDLE one cycle after out_ready rises.
REQ-039 flush at BUSY step 10, then accept UNSIGNED 9/3 -> no out_valid for aborted op; new result quotient=3, remainder=0 at normal latency.
REQ-040 rst asserted in DONE with out_ready=0 -> next cycle out_valid=0, in_ready=1, quotient=0, remainder=0.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared core types for the divider: operand interpretation and FSM state.
package divider_pkg;

    typedef enum logic {
        UNSIGNED = 1'b0,
        SIGNED   = 1'b1
    } sign_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/divider_if.sv
// Operand/result handshake bundle between a divider and its client.
interface divider_if #(
    parameter int unsigned LEN = 32
);
    logic                  in_valid;
    logic                  in_ready;
    divider_pkg::sign_t    sign;
    logic [LEN-1:0]        dividend;
    logic [LEN-1:0]        divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [LEN-1:0]        quotient;
    logic [LEN-1:0]        remainder;

    modport master (
        output in_valid, sign, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  in_valid, sign, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder
    );
endinterface

// File: rtl/divider_step.sv
// One restoring division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep or restore, emit the quotient bit.
module div_step #(
    parameter int unsigned LEN = 32
) (
    input  logic [LEN:0]   acc_in,
    input  logic [LEN-1:0] quo_in,
    input  logic [LEN-1:0] divisor,
    output logic [LEN:0]   acc_out,
    output logic [LEN-1:0] quo_out
);
    logic [LEN+1:0] shifted;
    logic [LEN+1:0] trial;

    // Trial subtraction; a borrow in the top bit means restore.
    always_comb begin
        shifted = {acc_in, quo_in[LEN-1]};
        trial   = shifted - {2'b00, divisor};
        if (trial[LEN+1]) begin
            acc_out = shifted[LEN:0];
            quo_out = {quo_in[LEN-2:0], 1'b0};
        end else begin
            acc_out = trial[LEN:0];
            quo_out = {quo_in[LEN-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/divider.sv
// Sequential restoring divider, one quotient bit per cycle, with
// signed/unsigned modes, divide-by-zero and overflow fast paths.
module divider
    import divider_pkg::*;
#(
    parameter int unsigned LEN = 32
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    divider_if.slave bus
);
    localparam int unsigned CW = $clog2(LEN) + 1;
    localparam logic [LEN-1:0] MIN_NEG = {1'b1, {(LEN-1){1'b0}}};

    div_state_t     state;
    div_state_t     state_next;

    logic [LEN:0]   acc;
    logic [LEN-1:0] quo;
    logic [LEN-1:0] dvs;
    logic [CW-1:0]  cnt;
    logic           q_neg;
    logic           r_neg;
    logic [LEN-1:0] q_out;
    logic [LEN-1:0] r_out;

    logic [LEN:0]   acc_step;
    logic [LEN-1:0] quo_step;

    logic           accept;
    logic           last_step;
    logic           dvd_neg;
    logic           dvs_neg;
    logic [LEN-1:0] dvd_mag;
    logic [LEN-1:0] dvs_mag;
    logic           div_zero;
    logic           overflow;

    div_step #(.LEN(LEN)) u_step (
        .acc_in  (acc),
        .quo_in  (quo),
        .divisor (dvs),
        .acc_out (acc_step),
        .quo_out (quo_step)
    );

    // Operand decode; flush blocks acceptance even while idle.
    always_comb begin
        dvd_neg   = (bus.sign == SIGNED) && bus.dividend[LEN-1];
        dvs_neg   = (bus.sign == SIGNED) && bus.divisor[LEN-1];
        dvd_mag   = dvd_neg ? -bus.dividend : bus.dividend;
        dvs_mag   = dvs_neg ? -bus.divisor  : bus.divisor;
        div_zero  = (bus.divisor == '0);
        overflow  = (bus.sign == SIGNED) && (bus.dividend == MIN_NEG) &&
                    (bus.divisor == '1);
        accept    = bus.in_valid && (state == IDLE) && !flush;
        last_step = (cnt == CW'(LEN - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and handshake outputs; flush overrides every transition.
    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (accept) state_next = (div_zero || overflow) ? DONE : BUSY;
            end
            BUSY: begin
                if (last_step) state_next = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // Datapath: latch magnitudes on accept, iterate in BUSY, sign-fix at the end.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            quo   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            q_out <= '0;
            r_out <= '0;
        end else if (accept) begin
            acc   <= '0;
            quo   <= dvd_mag;
            dvs   <= dvs_mag;
            cnt   <= '0;
            q_neg <= dvd_neg ^ dvs_neg;
            r_neg <= dvd_neg;
            if (div_zero) begin
                q_out <= '1;
                r_out <= bus.dividend;
            end else if (overflow) begin
                q_out <= bus.dividend;
                r_out <= '0;
            end
        end else if ((state == BUSY) && !flush) begin
            acc <= acc_step;
            quo <= quo_step;
            cnt <= cnt + 1'b1;
            if (last_step) begin
                q_out <= q_neg ? -quo_step : quo_step;
                r_out <= r_neg ? -acc_step[LEN-1:0] : acc_step[LEN-1:0];
            end
        end
    end

    assign bus.quotient  = q_out;
    assign bus.remainder = r_out;
endmodule
